reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_pkg.sv | 23 ++
 rtl/reg_scoreboard.sv | 82 ++++++++
 rtl/reg_file_mp.sv | 110 +++++++++++
 tb/tb_reg_file_mp.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp_pkg
// Purpose  : Shared defaults and helpers for the multi-port register file.
//            XLEN_DEFAULT  - data width in bits
//            NREGS_DEFAULT - number of architectural registers (power of two)
//            NREAD_DEFAULT - number of combinational read ports (1..4)
//            addr_width()  - register-address width for a given NREGS
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_mp_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NREAD_DEFAULT = 2;

    // Never returns 0 so that a degenerate NREGS still yields a legal vector.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : reg_file_mp_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Tracks registers with an outstanding write (busy) and keeps a
//            registered population count of the busy vector.
// Ports    : clock, reset        - clock, asynchronous active-low reset
//            issue_valid_i/rd_i  - mark register pending (x0 ignored)
//            wr0_en_i/addr_i     - qualified write port 0 (non-zero, active)
//            wr1_en_i/addr_i     - qualified write port 1 (non-zero, active)
//            busy_o              - one bit per register
//            pending_cnt_o       - number of set bits in busy_o
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid_i,
    input  logic [AW-1:0] issue_rd_i,
    input  logic          wr0_en_i,
    input  logic [AW-1:0] wr0_addr_i,
    input  logic          wr1_en_i,
    input  logic [AW-1:0] wr1_addr_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      pending_cnt_o
);

    localparam int CW = AW + 1;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [CW-1:0]    w_inc;
    logic [CW-1:0]    w_dec;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid_i && (issue_rd_i != '0)) begin
            w_set[issue_rd_i] = 1'b1;
        end
        if (wr0_en_i) begin
            w_clr[wr0_addr_i] = 1'b1;
        end
        if (wr1_en_i) begin
            w_clr[wr1_addr_i] = 1'b1;
        end
        w_clr[0] = 1'b0;

        // Set is applied after clear: a same-cycle issue is the newer event.
        busy_d = (busy_q & ~w_clr) | w_set;

        // Count actual transitions so the counter always matches busy.
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_inc = w_inc + CW'(busy_d[i] & ~busy_q[i]);
            w_dec = w_dec + CW'(busy_q[i] & ~busy_d[i]);
        end
        cnt_d = cnt_q + w_inc - w_dec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Register file with two write ports (port 1 has priority), NREAD
//            combinational read ports with same-cycle forwarding, x0 hardwired
//            to zero, and a busy scoreboard for outstanding writes.
// Ports    : clock, reset                          - clock, async active-low
//            regwrite0/write_reg0/write_data0      - write port 0
//            regwrite1/write_reg1/write_data1      - write port 1
//            read_reg_num / read_data              - packed read ports
//            issue_valid / issue_rd                - mark register pending
//            busy / read_busy / pending_cnt        - scoreboard status
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NREAD = NREAD_DEFAULT,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  regwrite0,
    input  logic [AW-1:0]         write_reg0,
    input  logic [XLEN-1:0]       write_data0,
    input  logic                  regwrite1,
    input  logic [AW-1:0]         write_reg1,
    input  logic [XLEN-1:0]       write_data1,
    input  logic [NREAD*AW-1:0]   read_reg_num,
    output logic [NREAD*XLEN-1:0] read_data,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic [NREGS-1:0]      busy,
    output logic [NREAD-1:0]      read_busy,
    output logic [AW:0]           pending_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Qualified write enables. Gating with reset keeps anything presented
    // during reset from being forwarded or clearing scoreboard bits.
    logic w_we0;
    logic w_we1;

    assign w_we0 = regwrite0 && (write_reg0 != '0) && reset;
    assign w_we1 = regwrite1 && (write_reg1 != '0) && reset;

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (w_we0) begin
            regs_d[write_reg0] = write_data0;
        end
        if (w_we1) begin
            regs_d[write_reg1] = write_data1;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .issue_valid_i (issue_valid && reset),
        .issue_rd_i    (issue_rd),
        .wr0_en_i      (w_we0),
        .wr0_addr_i    (write_reg0),
        .wr1_en_i      (w_we1),
        .wr1_addr_i    (write_reg1),
        .busy_o        (busy),
        .pending_cnt_o (pending_cnt)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] w_addr;
        logic          w_zero;
        logic          w_hit0;
        logic          w_hit1;

        assign w_addr = read_reg_num[k*AW +: AW];
        assign w_zero = (w_addr == '0);
        assign w_hit1 = w_we1 && (write_reg1 == w_addr);
        assign w_hit0 = w_we0 && (write_reg0 == w_addr);

        assign read_data[k*XLEN +: XLEN] = w_zero ? '0          :
                                           w_hit1 ? write_data1 :
                                           w_hit0 ? write_data0 :
                                                    regs_q[w_addr];

        // A write landing this cycle resolves the pending result.
        assign read_busy[k] = busy[w_addr] && !w_zero && !w_hit0 && !w_hit1;
    end

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic        clock;
    logic        reset;
    logic        regwrite0;
    logic [4:0]  write_reg0;
    logic [31:0] write_data0;
    logic        regwrite1;
    logic [4:0]  write_reg1;
    logic [31:0] write_data1;
    logic [9:0]  read_reg_num;
    logic [63:0] read_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic [1:0]  read_busy;
    logic [5:0]  pending_cnt;

    reg_file_mp dut (
        .clock        (clock),
        .reset        (reset),
        .regwrite0    (regwrite0),
        .write_reg0   (write_reg0),
        .write_data0  (write_data0),
        .regwrite1    (regwrite1),
        .write_reg1   (write_reg1),
        .write_data1  (write_data1),
        .read_reg_num (read_reg_num),
        .read_data    (read_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .busy         (busy),
        .read_busy    (read_busy),
        .pending_cnt  (pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] busy;
        logic [5:0]  cnt;
    } post_t;

    vec_t  tbl[$];
    post_t sbq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                       input logic [1:0] e_rb, input logic [31:0] e_busy,
                       input logic [5:0] e_cnt);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.iv = iv; v.ird = ird; v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb = e_rb;
        v.e_busy = e_busy; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic idle();
        regwrite0 = 0; write_reg0 = 0; write_data0 = 0;
        regwrite1 = 0; write_reg1 = 0; write_data1 = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        post_t p;
        vec_t  v;

        //   we0 wa0 wd0   we1 wa1 wd1   iv ird  ra0 ra1  rd0  rd1  rb     busy          cnt
        add(1, 10, 100,   1, 11, 200,   0, 0,   10, 11,  100, 200, 2'b00, 32'h0000_0000, 0);
        add(1, 12, 1,     1, 12, 2,     0, 0,   12, 10,  2,   100, 2'b00, 32'h0000_0000, 0);
        add(0, 0,  0,     0, 0,  0,     0, 0,   11, 12,  200, 2,   2'b00, 32'h0000_0000, 0);
        add(1, 0,  999,   1, 0,  999,   1, 0,   0,  10,  0,   100, 2'b00, 32'h0000_0000, 0);
        add(0, 0,  0,     0, 0,  0,     0, 0,   0,  0,   0,   0,   2'b00, 32'h0000_0000, 0);
        add(1, 5,  555,   0, 0,  0,     0, 0,   5,  0,   555, 0,   2'b00, 32'h0000_0000, 0);
        add(0, 0,  0,     0, 0,  0,     0, 0,   5,  12,  555, 2,   2'b00, 32'h0000_0000, 0);
        add(0, 0,  0,     0, 0,  0,     1, 7,   7,  5,   0,   555, 2'b00, 32'h0000_0080, 1);
        add(0, 0,  0,     0, 0,  0,     0, 0,   7,  3,   0,   0,   2'b01, 32'h0000_0080, 1);
        add(1, 7,  9,     0, 0,  0,     0, 0,   7,  7,   9,   9,   2'b00, 32'h0000_0000, 0);
        add(0, 0,  0,     1, 7,  11,    1, 7,   7,  0,   11,  0,   2'b00, 32'h0000_0080, 1);
        add(1, 7,  12,    0, 0,  0,     1, 7,   7,  0,   12,  0,   2'b00, 32'h0000_0080, 1);
        add(1, 7,  13,    0, 0,  0,     1, 3,   7,  3,   13,  0,   2'b00, 32'h0000_0008, 1);
        add(0, 0,  0,     0, 0,  0,     1, 4,   3,  4,   0,   0,   2'b01, 32'h0000_0018, 2);
        add(1, 4,  44,    1, 3,  33,    1, 9,   3,  4,   33,  44,  2'b00, 32'h0000_0200, 1);
        add(0, 0,  0,     0, 0,  0,     1, 3,   9,  3,   0,   33,  2'b01, 32'h0000_0208, 2);
        add(0, 0,  0,     0, 0,  0,     1, 4,   3,  4,   33,  44,  2'b01, 32'h0000_0218, 3);

        // Reset held with a write of x5 = 7 presented; it must be discarded.
        idle();
        reset = 1'b0;
        read_reg_num = {5'd0, 5'd5};
        regwrite0 = 1; write_reg0 = 5; write_data0 = 7;
        issue_valid = 1; issue_rd = 6;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_cnt", 64'(pending_cnt), 64'h0);
        @(negedge clock);
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_reset_x5", 64'(read_data[31:0]), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'h0);
        chk("post_reset_cnt", 64'(pending_cnt), 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            v = tbl[i];
            regwrite0 = v.we0; write_reg0 = v.wa0; write_data0 = v.wd0;
            regwrite1 = v.we1; write_reg1 = v.wa1; write_data1 = v.wd1;
            issue_valid = v.iv; issue_rd = v.ird;
            read_reg_num = {v.ra1, v.ra0};
            p.idx = i; p.busy = v.e_busy; p.cnt = v.e_cnt;
            sbq.push_back(p);
            #1;
            chk($sformatf("v%0d_rd0", i), 64'(read_data[31:0]), 64'(v.e_rd0));
            chk($sformatf("v%0d_rd1", i), 64'(read_data[63:32]), 64'(v.e_rd1));
            chk($sformatf("v%0d_rbusy", i), 64'(read_busy), 64'(v.e_rb));
            @(posedge clock);
            #1;
            idle();
            p = sbq.pop_front();
            chk($sformatf("v%0d_busy", p.idx), 64'(busy), 64'(p.busy));
            chk($sformatf("v%0d_cnt", p.idx), 64'(pending_cnt), 64'(p.cnt));
        end

        // Mid-cycle asynchronous reset with x3/x4/x9 busy and x3 = 33 stored.
        read_reg_num = {5'd4, 5'd3};
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'h0);
        chk("async_cnt", 64'(pending_cnt), 64'h0);
        chk("async_x3", 64'(read_data[31:0]), 64'd0);
        chk("async_x4", 64'(read_data[63:32]), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("after_async_x3", 64'(read_data[31:0]), 64'd0);
        chk("after_async_rbusy", 64'(read_busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_file_mp
`default_nettype wire
